stage_1: RTL and testbench
==========================

STAGE_1 -- requirements
Module: stage_1

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 clk_en  input  1  global enable; low = all state frozen.
REQ-005 start  input  1  single-cycle request; samples x_one/x_two.
REQ-006 x_one, x_two  input  32 each  IEEE-754 single-precision operands.
REQ-007 done  output  1  one-cycle pulse; results valid.
REQ-008 out_one, out_two  output  22 each  CORDIC angle, signed two's complement, Q2.20.
REQ-009 half_out_one, half_out_two  output  32 each  IEEE-754 single, x/2.
REQ-010 square_out_one, square_out_two  output  32 each  IEEE-754 single, x*x.

Function
REQ-011 out_k SHALL equal (x_k - 128)/128 * 2^20, rounded toward zero.
- Saturate to 22'h1FFFFF / 22'h200000 when out of range.
- NaN -> 0; +Inf / -Inf -> positive / negative saturation.
REQ-012 half_out_k SHALL be x_k with the exponent field decremented.
- Exponent 0 or result exponent 0 -> signed zero; denormals are flushed to zero.
- Inf and NaN pass through unchanged.
REQ-013 square_out_k SHALL be the IEEE product x_k*x_k.
- Sign bit always 0.
- Denormal inputs and underflow results -> +0.
- Overflow -> +Inf (0x7F800000); NaN input -> 0x7FC00000.
REQ-014 Both lanes SHALL be computed in parallel by identical datapaths.
REQ-015 start is accepted only on a rising edge with clk_en=1; start with clk_en=0 is ignored.
REQ-016 Latency: done SHALL pulse exactly 4 enabled clock cycles after the accepted start.
- Cycles with clk_en=0 do not count toward latency.
REQ-017 The pipeline SHALL be fully pipelined: a start on every enabled cycle gives a done on every enabled cycle, with results in order.
REQ-018 All outputs SHALL be registered and SHALL hold their last values until the next done.
REQ-019 While clk_en=0, all pipeline registers, valid bits and outputs SHALL hold; done holds its value.
REQ-020 Operands SHALL be sampled only on the start cycle; later input changes SHALL NOT affect in-flight results.

Reset
REQ-021 rst=1 SHALL immediately clear all outputs to 0, done to 0, and all pipeline valid bits.
REQ-022 A reset mid-operation SHALL discard in-flight requests; no done pulse for them after reset release.
REQ-023 A start on the first enabled edge after reset release SHALL be accepted normally.

Configuration
REQ-024 When STAGE_1_SQUARE_RNE_EN is defined, the squarer SHALL round to nearest, ties to even.
REQ-025 When STAGE_1_SQUARE_RNE_EN is undefined, the squarer SHALL truncate (round toward zero); all other behaviour is identical.

Verification
REQ-026 x_one=0x43000000 (128.0), start, clk_en=1 -> done at +4 cycles; out_one=22'h000000, half_out_one=0x42800000, square_out_one=0x46800000.
REQ-027 x_two=0x00000000 (0.0) -> out_two=22'h300000 (-1.0), half_out_two=0x00000000, square_out_two=0x00000000.
REQ-028 x_one=0x437F0000 (255.0) -> out_one=22'h0FE000, half_out_one=0x42FF0000, square_out_one=0x477E0100.
REQ-029 Back-to-back starts of 128.0 then 255.0, with clk_en low for 2 cycles mid-flight -> two done pulses on consecutive enabled cycles, each at 4 enabled cycles after its start, results in order.
REQ-030 start held with clk_en=0 -> no done pulse.
REQ-031 rst pulsed 2 cycles after start -> all outputs 0 and no done pulse.

Source files
------------

// File: rtl/stage_1.sv
// stage_1: two identical float lanes -> Q2.20 CORDIC angle, x/2 and x*x (build option STAGE_1_SQUARE_RNE_EN).
// Latency: done pulses 4 enabled cycles after an accepted start; one result per enabled cycle.
// No backpressure; clk_en=0 freezes every register. Squarer truncates unless STAGE_1_SQUARE_RNE_EN is defined (RNE).
module stage_1 (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] x_one,
   input  logic [31:0] x_two,
   output logic        done,
   output logic [21:0] out_one,
   output logic [21:0] out_two,
   output logic [31:0] half_out_one,
   output logic [31:0] half_out_two,
   output logic [31:0] square_out_one,
   output logic [31:0] square_out_two
);

`ifdef STAGE_1_SQUARE_RNE_EN
   localparam bit ROUND_NEAREST = 1'b1;
`else
   localparam bit ROUND_NEAREST = 1'b0;
`endif

   localparam logic [1:0] CLS_NUM  = 2'd0;
   localparam logic [1:0] CLS_ZERO = 2'd1;
   localparam logic [1:0] CLS_INF  = 2'd2;
   localparam logic [1:0] CLS_NAN  = 2'd3;

   // (x - 128) * 2^13 rounded toward zero, saturated to the Q2.20 range
   function automatic logic [21:0] to_angle(input logic [31:0] x);
      logic [7:0]         e;
      logic [23:0]        m;
      logic [49:0]        t;
      logic [49:0]        sh;
      logic [49:0]        back;
      logic [25:0]        ip;
      logic               frac;
      logic signed [27:0] v;
      int                 a;
      e = x[30:23];
      to_angle = 22'h000000;
      if (e == 8'hFF) begin
         if (x[22:0] != 23'd0) to_angle = 22'h000000;
         else                  to_angle = x[31] ? 22'h200000 : 22'h1FFFFF;
      end else if (e >= 8'd140) begin
         to_angle = x[31] ? 22'h200000 : 22'h1FFFFF;
      end else begin
         // |x| * 2^13 as integer part ip plus a nonzero-fraction flag
         m    = {e != 8'd0, x[22:0]};
         t    = {m, 26'd0};
         a    = 139 - int'(e);
         sh   = t >> a;
         ip   = sh[49:24];
         back = {ip, 24'd0} << a;
         frac = (back != t);
         // below 128 the result is negative, so toward zero means ceiling
         if (!x[31] && frac && (ip < 26'h0100000)) ip = ip + 26'd1;
         v = $signed({2'b00, ip});
         v = x[31] ? (-v - 28'sd1048576) : (v - 28'sd1048576);
         if (v > 28'sd2097151)       to_angle = 22'h1FFFFF;
         else if (v < -28'sd2097152) to_angle = 22'h200000;
         else                        to_angle = v[21:0];
      end
   endfunction

   // exponent decrement; zero, denormal and exponent-1 inputs collapse to signed zero
   function automatic logic [31:0] to_half(input logic [31:0] x);
      if (x[30:23] == 8'hFF)      to_half = x;
      else if (x[30:23] <= 8'd1)  to_half = {x[31], 31'd0};
      else                        to_half = {x[31], x[30:23] - 8'd1, x[22:0]};
   endfunction

   function automatic logic [23:0] mant24(input logic [30:0] f);
      mant24 = {f[30:23] != 8'd0, f[22:0]};
   endfunction

   function automatic logic [1:0] sq_class(input logic [30:0] f);
      if (f[30:23] == 8'hFF)      sq_class = (f[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
      else if (f[30:23] == 8'd0)  sq_class = CLS_ZERO;
      else                        sq_class = CLS_NUM;
   endfunction

   // normalise the 48-bit mantissa product; returns {exponent[9:0], fraction[22:0]}
   function automatic logic [32:0] sq_norm(input logic [47:0] p, input logic [9:0] e_in);
      logic [9:0]  e;
      logic [22:0] mant;
      logic        g;
      logic        st;
      logic        lsb;
      logic [23:0] sum;
      e = e_in;
      if (p[47]) begin
         mant = p[46:24]; g = p[23]; st = |p[22:0]; lsb = p[24];
         e = e + 10'd1;
      end else begin
         mant = p[45:23]; g = p[22]; st = |p[21:0]; lsb = p[23];
      end
      if (ROUND_NEAREST && g && (st || lsb)) begin
         sum  = {1'b0, mant} + 24'd1;
         mant = sum[22:0];
         if (sum[23]) e = e + 10'd1;
      end
      sq_norm = {e, mant};
   endfunction

   function automatic logic [31:0] sq_pack(input logic [1:0] cls, input logic [32:0] n);
      logic signed [9:0] e;
      e = $signed(n[32:23]);
      case (cls)
         CLS_NAN:  sq_pack = 32'h7FC00000;
         CLS_INF:  sq_pack = 32'h7F800000;
         CLS_ZERO: sq_pack = 32'h00000000;
         default: begin
            if (e >= 10'sd255)    sq_pack = 32'h7F800000;
            else if (e <= 10'sd0) sq_pack = 32'h00000000;
            else                  sq_pack = {1'b0, e[7:0], n[22:0]};
         end
      endcase
   endfunction

   logic [31:0] x_in  [2];
   logic        v1, v2, v3, v4;
   logic [31:0] op    [2];
   logic [21:0] ang2  [2];
   logic [21:0] ang3  [2];
   logic [21:0] ang4  [2];
   logic [31:0] hlf2  [2];
   logic [31:0] hlf3  [2];
   logic [31:0] hlf4  [2];
   logic [47:0] sq_p  [2];
   logic [9:0]  sq_e2 [2];
   logic [1:0]  cls2  [2];
   logic [1:0]  cls3  [2];
   logic [32:0] nrm3  [2];
   logic [31:0] sq4   [2];
   logic [21:0] ang_q [2];
   logic [31:0] hlf_q [2];
   logic [31:0] sq_q  [2];

   assign x_in[0] = x_one;
   assign x_in[1] = x_two;

   // valid chain and done pulse; everything holds while clk_en is low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1   <= 1'b0;
         v2   <= 1'b0;
         v3   <= 1'b0;
         v4   <= 1'b0;
         done <= 1'b0;
      end else if (clk_en) begin
         v1   <= start;
         v2   <= v1;
         v3   <= v2;
         v4   <= v3;
         done <= v4;
      end
   end

   // per-lane datapath: capture, convert/multiply, normalise, pack, publish on done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            op[i]    <= '0;
            ang2[i]  <= '0;
            ang3[i]  <= '0;
            ang4[i]  <= '0;
            hlf2[i]  <= '0;
            hlf3[i]  <= '0;
            hlf4[i]  <= '0;
            sq_p[i]  <= '0;
            sq_e2[i] <= '0;
            cls2[i]  <= '0;
            cls3[i]  <= '0;
            nrm3[i]  <= '0;
            sq4[i]   <= '0;
            ang_q[i] <= '0;
            hlf_q[i] <= '0;
            sq_q[i]  <= '0;
         end
      end else if (clk_en) begin
         for (int i = 0; i < 2; i++) begin
            if (start) op[i] <= x_in[i];
            ang2[i]  <= to_angle(op[i]);
            hlf2[i]  <= to_half(op[i]);
            sq_p[i]  <= 48'(mant24(op[i][30:0])) * 48'(mant24(op[i][30:0]));
            sq_e2[i] <= {1'b0, op[i][30:23], 1'b0} - 10'd127;
            cls2[i]  <= sq_class(op[i][30:0]);
            ang3[i]  <= ang2[i];
            hlf3[i]  <= hlf2[i];
            cls3[i]  <= cls2[i];
            nrm3[i]  <= sq_norm(sq_p[i], sq_e2[i]);
            ang4[i]  <= ang3[i];
            hlf4[i]  <= hlf3[i];
            sq4[i]   <= sq_pack(cls3[i], nrm3[i]);
            if (v4) begin
               ang_q[i] <= ang4[i];
               hlf_q[i] <= hlf4[i];
               sq_q[i]  <= sq4[i];
            end
         end
      end
   end

   assign out_one        = ang_q[0];
   assign out_two        = ang_q[1];
   assign half_out_one   = hlf_q[0];
   assign half_out_two   = hlf_q[1];
   assign square_out_one = sq_q[0];
   assign square_out_two = sq_q[1];

endmodule

// File: tb/tb_stage_1.sv
// tb_stage_1: scoreboard bench for stage_1 using a table of operands with known results.
// Expected results are queued at start and compared when done pulses on an enabled cycle.
// Covers reset, latency with stalls, streaming, disabled starts and mid-flight reset.
module tb_stage_1;
   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic        start;
   logic [31:0] x_one;
   logic [31:0] x_two;
   logic        done;
   logic [21:0] out_one;
   logic [21:0] out_two;
   logic [31:0] half_out_one;
   logic [31:0] half_out_two;
   logic [31:0] square_out_one;
   logic [31:0] square_out_two;

   stage_1 dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
      .x_one(x_one), .x_two(x_two), .done(done),
      .out_one(out_one), .out_two(out_two),
      .half_out_one(half_out_one), .half_out_two(half_out_two),
      .square_out_one(square_out_one), .square_out_two(square_out_two)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [21:0] a1;
      logic [21:0] a2;
      logic [31:0] h1;
      logic [31:0] h2;
      logic [31:0] s1;
      logic [31:0] s2;
      int          t;
   } exp_t;

`ifdef STAGE_1_SQUARE_RNE_EN
   localparam logic [31:0] SQ_TIE = 32'h40100002;
`else
   localparam logic [31:0] SQ_TIE = 32'h40100001;
`endif

   localparam int N = 17;
   localparam logic [31:0] TX [N] = '{
      32'h43000000, 32'h00000000, 32'h437F0000, 32'h3F800000, 32'hBF800000, 32'h447A0000,
      32'hC3960000, 32'h7F800000, 32'h7FC00001, 32'hFF800000, 32'h3F800001, 32'h43000001,
      32'h7F000000, 32'h1F800000, 32'h80400000, 32'h00800000, 32'h3FC00001};
   localparam logic [21:0] TA [N] = '{
      22'h000000, 22'h300000, 22'h0FE000, 22'h302000, 22'h2FE000, 22'h1FFFFF,
      22'h200000, 22'h1FFFFF, 22'h000000, 22'h200000, 22'h302001, 22'h000000,
      22'h1FFFFF, 22'h300001, 22'h300000, 22'h300001, 22'h303001};
   localparam logic [31:0] TH [N] = '{
      32'h42800000, 32'h00000000, 32'h42FF0000, 32'h3F000000, 32'hBF000000, 32'h43FA0000,
      32'hC3160000, 32'h7F800000, 32'h7FC00001, 32'hFF800000, 32'h3F000001, 32'h42800001,
      32'h7E800000, 32'h1F000000, 32'h80000000, 32'h00000000, 32'h3F400001};
   localparam logic [31:0] TS [N] = '{
      32'h46800000, 32'h00000000, 32'h477E0100, 32'h3F800000, 32'h3F800000, 32'h49742400,
      32'h47AFC800, 32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h3F800002, 32'h46800002,
      32'h7F800000, 32'h00000000, 32'h00000000, 32'h00000000, SQ_TIE};

   exp_t sb[$];
   exp_t last_e;
   exp_t mon_e;
   logic mon_want;
   logic last_en = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   ecyc = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%08h want=%08h", tag, got, want);
      end
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_done"}, 32'(done), 32'd0);
      check_val({tag, "_out_one"}, 32'(out_one), 32'd0);
      check_val({tag, "_out_two"}, 32'(out_two), 32'd0);
      check_val({tag, "_half_one"}, half_out_one, 32'd0);
      check_val({tag, "_half_two"}, half_out_two, 32'd0);
      check_val({tag, "_sq_one"}, square_out_one, 32'd0);
      check_val({tag, "_sq_two"}, square_out_two, 32'd0);
   endtask

   // count enabled edges so latency is measured in enabled cycles only
   always @(posedge clk) begin
      last_en = clk_en & ~rst;
      if (clk_en && !rst) ecyc++;
   end

   // on each enabled cycle: done must match the scoreboard head; otherwise outputs hold
   always @(negedge clk) begin
      if (last_en) begin
         mon_want = (sb.size() > 0) && (sb[0].t + 4 == ecyc);
         check_val("done_timing", 32'(done), 32'(mon_want));
         if (mon_want) begin
            mon_e = sb.pop_front();
            check_val("out_one", 32'(out_one), 32'(mon_e.a1));
            check_val("out_two", 32'(out_two), 32'(mon_e.a2));
            check_val("half_out_one", half_out_one, mon_e.h1);
            check_val("half_out_two", half_out_two, mon_e.h2);
            check_val("square_out_one", square_out_one, mon_e.s1);
            check_val("square_out_two", square_out_two, mon_e.s2);
            last_e = mon_e;
         end else begin
            check_val("hold_out_one", 32'(out_one), 32'(last_e.a1));
            check_val("hold_half_two", half_out_two, last_e.h2);
            check_val("hold_sq_one", square_out_one, last_e.s1);
         end
      end
   end

   task automatic issue(input int i, input int j);
      exp_t e;
      @(posedge clk); #1;
      clk_en = 1'b1;
      start  = 1'b1;
      x_one  = TX[i];
      x_two  = TX[j];
      e.a1 = TA[i]; e.a2 = TA[j];
      e.h1 = TH[i]; e.h2 = TH[j];
      e.s1 = TS[i]; e.s2 = TS[j];
      e.t  = ecyc + 1;
      sb.push_back(e);
   endtask

   // operands are scrambled on idle cycles so in-flight results must not depend on them
   task automatic idle(input logic en);
      @(posedge clk); #1;
      clk_en = en;
      start  = 1'b0;
      x_one  = $urandom;
      x_two  = $urandom;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 20) begin
         idle(1'b1);
         n++;
      end
      idle(1'b1);
      check_val("drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got=running want=finished");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; clk_en = 1'b0; start = 1'b0; x_one = '0; x_two = '0;
      last_e = '0;
      @(posedge clk); #1;
      check_zero("reset");
      @(negedge clk); rst = 1'b0;

      // first enabled edge after release: 128.0 and 0.0
      issue(0, 1);
      drain();
      // 255.0 and 1.0
      issue(2, 3);
      drain();
      // full-rate stream over the table
      for (int k = 0; k < N; k++) issue(k, N - 1 - k);
      drain();
      // 128 then 255 back to back, clk_en low two cycles mid-flight
      issue(0, 4);
      issue(2, 5);
      idle(1'b1);
      idle(1'b0);
      idle(1'b0);
      drain();
      // stream with scattered stalls
      for (int k = 0; k < 10; k++) begin
         issue(k, k + 7);
         if (k % 3 == 0) idle(1'b0);
      end
      drain();
      // start held while disabled: must be ignored
      repeat (6) begin
         @(posedge clk); #1;
         clk_en = 1'b0; start = 1'b1; x_one = TX[2]; x_two = TX[0];
      end
      repeat (8) idle(1'b1);
      // reset two cycles after a start: outputs clear at once, no late done
      issue(2, 6);
      idle(1'b1);
      idle(1'b1);
      #2;
      rst = 1'b1;
      sb.delete();
      last_e = '0;
      #1;
      check_zero("midreset");
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      repeat (8) idle(1'b1);
      // normal operation resumes
      issue(16, 10);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
